// File: rtl/id_ex_stage_pkg.sv
// Shared RV32I types for the ID/EX boundary: opcodes, decoder control word,
// the ID->EX bundle, and source-operand usage helpers.
package id_ex_stage_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef struct packed {
        rv32i_opcode opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [3:0]  aluop;
        logic        load_regfile;
        logic        mem_read;
        logic        mem_write;
    } rv32i_control_word;

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        rv32i_control_word ctrl;
        logic [31:0]       rs1_data;
        logic [31:0]       rs2_data;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic [31:0]       i_imm;
        logic [31:0]       s_imm;
        logic [31:0]       b_imm;
        logic [31:0]       u_imm;
        logic [31:0]       j_imm;
    } id_ex_t;

    function automatic logic uses_rs1(input rv32i_opcode op);
        case (op)
            op_lui, op_auipc, op_jal: return 1'b0;
            default:                  return 1'b1;
        endcase
    endfunction

    function automatic logic uses_rs2(input rv32i_opcode op);
        case (op)
            op_br, op_store, op_reg: return 1'b1;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_ex_stage_imm_gen.sv
// RV32I immediate extraction: one instruction word in, all five
// sign-extended immediate formats out.
module imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] i_imm,
    output logic [31:0] s_imm,
    output logic [31:0] b_imm,
    output logic [31:0] u_imm,
    output logic [31:0] j_imm
);

    assign i_imm = {{21{instr[31]}}, instr[30:20]};
    assign s_imm = {{21{instr[31]}}, instr[30:25], instr[11:7]};
    assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25],
                    instr[11:8], 1'b0};
    assign u_imm = {instr[31:12], 12'b0};
    assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20],
                    instr[30:21], 1'b0};

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with load-use bubble insertion,
// flush handling and saturating stall/flush event counters.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_instr,
    input  rv32i_control_word id_ctrl,
    input  logic [31:0]       id_rs1_data,
    input  logic [31:0]       id_rs2_data,
    input  logic              flush,
    input  logic              ex_ready,
    output logic              ex_valid,
    output id_ex_t            ex_bundle,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        hazard;
    id_ex_t      next_bundle;

    assign id_rs1 = id_instr[19:15];
    assign id_rs2 = id_instr[24:20];
    assign id_rd  = id_instr[11:7];

    imm_gen u_imm_gen (
        .instr (id_instr),
        .i_imm (i_imm),
        .s_imm (s_imm),
        .b_imm (b_imm),
        .u_imm (u_imm),
        .j_imm (j_imm)
    );

    // A load in EX whose rd feeds the ID instruction must wait one cycle.
    assign rs1_hit = uses_rs1(id_ctrl.opcode) && (id_rs1 == ex_bundle.rd);
    assign rs2_hit = uses_rs2(id_ctrl.opcode) && (id_rs2 == ex_bundle.rd);
    assign hazard  = id_valid && ex_valid && ex_bundle.ctrl.mem_read
                     && (ex_bundle.rd != 5'd0) && (rs1_hit || rs2_hit);

    assign id_ready = rst && !flush && !hazard && (!ex_valid || ex_ready);

    always_comb begin
        next_bundle          = '0;
        next_bundle.pc       = id_pc;
        next_bundle.instr    = id_instr;
        next_bundle.ctrl     = id_ctrl;
        next_bundle.rs1_data = id_rs1_data;
        next_bundle.rs2_data = id_rs2_data;
        next_bundle.rs1      = id_rs1;
        next_bundle.rs2      = id_rs2;
        next_bundle.rd       = id_rd;
        next_bundle.i_imm    = i_imm;
        next_bundle.s_imm    = s_imm;
        next_bundle.b_imm    = b_imm;
        next_bundle.u_imm    = u_imm;
        next_bundle.j_imm    = j_imm;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_valid  <= 1'b0;
            ex_bundle <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            ex_valid <= 1'b0;
            if ((ex_valid || id_valid) && !(&flush_cnt))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (hazard && ex_ready) begin
            ex_valid <= 1'b0;
            if (!(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end else if (id_valid && id_ready) begin
            ex_valid  <= 1'b1;
            ex_bundle <= next_bundle;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed scenarios then random traffic
// against a slot-occupancy reference model.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              id_valid = 1'b0;
    logic              id_ready;
    logic [31:0]       id_pc = '0;
    logic [31:0]       id_instr = '0;
    rv32i_control_word id_ctrl = '0;
    logic [31:0]       id_rs1_data = '0;
    logic [31:0]       id_rs2_data = '0;
    logic              flush = 1'b0;
    logic              ex_ready = 1'b0;
    logic              ex_valid;
    id_ex_t            ex_bundle;
    logic [31:0]       stall_cnt;
    logic [31:0]       flush_cnt;

    id_ex_stage #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .id_ctrl     (id_ctrl),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .flush       (flush),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .ex_bundle   (ex_bundle),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: the stage is a one-entry slot; queue holds the expected
    // bundle of whatever instruction currently occupies that slot.
    id_ex_t      sb_q[$];
    logic        m_valid = 1'b0;
    logic        m_memread = 1'b0;
    logic [4:0]  m_rd = '0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    rv32i_opcode ops[10] = '{op_lui, op_auipc, op_jal, op_jalr, op_br,
                             op_load, op_store, op_imm, op_reg, op_csr};

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] f_i(input logic [31:0] x);
        return 32'($signed(x) >>> 20);
    endfunction

    function automatic logic [31:0] f_s(input logic [31:0] x);
        logic [31:0] r;
        r = 32'($signed(x) >>> 25) << 5;
        r[4:0] = x[11:7];
        return r;
    endfunction

    function automatic logic [31:0] f_b(input logic [31:0] x);
        logic [31:0] r;
        r = 32'($signed(x) >>> 31) << 12;
        r[11] = x[7];
        r[10:5] = x[30:25];
        r[4:1] = x[11:8];
        r[0] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] f_j(input logic [31:0] x);
        logic [31:0] r;
        r = 32'($signed(x) >>> 31) << 20;
        r[19:12] = x[19:12];
        r[11] = x[20];
        r[10:1] = x[30:21];
        r[0] = 1'b0;
        return r;
    endfunction

    function automatic id_ex_t expect_bundle(
        input logic [31:0] pc, input logic [31:0] ins,
        input rv32i_control_word c, input logic [31:0] d1,
        input logic [31:0] d2);
        id_ex_t e;
        e.pc = pc;
        e.instr = ins;
        e.ctrl = c;
        e.rs1_data = d1;
        e.rs2_data = d2;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        e.i_imm = f_i(ins);
        e.s_imm = f_s(ins);
        e.b_imm = f_b(ins);
        e.u_imm = ins & 32'hFFFF_F000;
        e.j_imm = f_j(ins);
        return e;
    endfunction

    function automatic rv32i_control_word mk_ctrl(input rv32i_opcode op);
        rv32i_control_word c;
        c.opcode = op;
        c.funct3 = 3'($urandom);
        c.funct7 = 7'($urandom);
        c.aluop = 4'($urandom);
        c.load_regfile = !(op inside {op_br, op_store});
        c.mem_read = (op == op_load);
        c.mem_write = (op == op_store);
        return c;
    endfunction

    // One clock of stimulus; model predicts this cycle's outputs and the
    // effect of the coming edge. gone=1 when ID's instruction leaves ID.
    task automatic cycle(input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input rv32i_control_word c,
                         input logic [31:0] d1, input logic [31:0] d2,
                         input logic er, input logic fl, output logic gone);
        logic u1, u2, haz, rdy;
        @(posedge clk);
        #1;
        id_valid = v;
        id_pc = pc;
        id_instr = ins;
        id_ctrl = c;
        id_rs1_data = d1;
        id_rs2_data = d2;
        ex_ready = er;
        flush = fl;
        @(negedge clk);
        #1;
        u1 = !(c.opcode inside {op_lui, op_auipc, op_jal});
        u2 = c.opcode inside {op_br, op_store, op_reg};
        haz = v && m_valid && m_memread && (m_rd != 0)
              && ((u1 && ins[19:15] == m_rd) || (u2 && ins[24:20] == m_rd));
        rdy = !fl && !haz && (!m_valid || er);
        chk("id_ready", 32'(id_ready), 32'(rdy));
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        if (fl) begin
            if ((m_valid || v) && m_flush != '1) m_flush++;
            if (m_valid) void'(sb_q.pop_back());
            m_valid = 1'b0;
        end else if (haz && er) begin
            m_valid = 1'b0;
            if (m_stall != '1) m_stall++;
        end else if (v && rdy) begin
            sb_q.push_back(expect_bundle(pc, ins, c, d1, d2));
            m_valid = 1'b1;
            m_memread = c.mem_read;
            m_rd = ins[11:7];
        end else if (er) begin
            m_valid = 1'b0;
        end
        gone = fl || (v && rdy);
    endtask

    task automatic idle(input logic er);
        logic g;
        cycle(1'b0, '0, '0, mk_ctrl(op_imm), '0, '0, er, 1'b0, g);
    endtask

    task automatic issue(input logic [31:0] ins, input rv32i_opcode op,
                         input logic er, input logic fl);
        logic g;
        cycle(1'b1, 32'($urandom) & ~32'h3, ins, mk_ctrl(op),
              $urandom, $urandom, er, fl, g);
    endtask

    // Issue until the instruction is taken, bounded.
    task automatic issue_until(input logic [31:0] ins, input rv32i_opcode op);
        logic g;
        rv32i_control_word c;
        c = mk_ctrl(op);
        g = 1'b0;
        for (int k = 0; k < 8 && !g; k++)
            cycle(1'b1, 32'h100, ins, c, 32'h11, 32'h22, 1'b1, 1'b0, g);
        chk("issue_timeout", 32'(g), 32'd1);
    endtask

    // Monitor: whenever EX sees a valid bundle it must match the oldest
    // expected entry; it retires when EX takes it.
    always @(negedge clk) begin
        if (rst && ex_valid) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL bundle_unexpected: ex_valid=1 with nothing expected");
            end else begin
                if (ex_bundle !== sb_q[0]) begin
                    n_err++;
                    $display("FAIL bundle: got %h expected %h",
                             ex_bundle, sb_q[0]);
                end
                if (ex_ready && !flush) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        logic g;
        logic have;
        logic v, er, fl;
        logic [31:0] pc, ins, d1, d2;
        rv32i_control_word c;

        repeat (2) @(negedge clk);
        chk("rst_ex_valid", 32'(ex_valid), 32'd0);
        chk("rst_id_ready", 32'(id_ready), 32'd0);
        chk("rst_bundle_op", 32'(ex_bundle.ctrl.opcode), 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);
        rst = 1'b1;

        // Reset mid-stream while an instruction is held.
        issue(32'h0050_0093, op_imm, 1'b1, 1'b0);
        issue(32'h0020_8193, op_imm, 1'b0, 1'b0);
        idle(1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_ex_valid", 32'(ex_valid), 32'd0);
        chk("midrst_id_ready", 32'(id_ready), 32'd0);
        chk("midrst_stall", stall_cnt, 32'd0);
        chk("midrst_flush", flush_cnt, 32'd0);
        sb_q.delete();
        m_valid = 1'b0;
        m_stall = '0;
        m_flush = '0;
        @(negedge clk);
        rst = 1'b1;

        // addi x1,x0,5 / add x2,x1,x1 back to back.
        issue(32'h0050_0093, op_imm, 1'b1, 1'b0);
        issue(32'h0010_8133, op_reg, 1'b1, 1'b0);
        idle(1'b1);
        chk("b2b_stall", stall_cnt, 32'd0);

        // lw x5,0(x1) / add x6,x5,x2 -> one bubble.
        issue_until(32'h0000_A283, op_load);
        issue_until(32'h0022_8333, op_reg);
        idle(1'b1);
        chk("loaduse_stall", stall_cnt, 32'd1);
        // lw x0,0(x1) / add x6,x0,x2 -> no bubble.
        issue_until(32'h0000_A003, op_load);
        issue_until(32'h0020_0333, op_reg);
        idle(1'b1);
        chk("x0_nostall", stall_cnt, 32'd1);

        // Backpressure: hold for 3 cycles with a pending instruction.
        issue(32'h0000_0113, op_imm, 1'b1, 1'b0);
        c = mk_ctrl(op_reg);
        for (int k = 0; k < 3; k++)
            cycle(1'b1, 32'h200, 32'h0031_8233, c, 32'h5, 32'h6,
                  1'b0, 1'b0, g);
        cycle(1'b1, 32'h200, 32'h0031_8233, c, 32'h5, 32'h6, 1'b1, 1'b0, g);
        idle(1'b1);

        // Flush with a held and an incoming instruction.
        issue(32'h0000_0193, op_imm, 1'b1, 1'b0);
        issue(32'h0000_0213, op_imm, 1'b0, 1'b1);
        idle(1'b1);
        chk("flush_cnt_one", flush_cnt, 32'd1);

        // Immediate spot checks.
        issue(32'hFE00_0EE3, op_br, 1'b1, 1'b0);
        idle(1'b0);
        chk("b_imm", ex_bundle.b_imm, 32'hFFFF_FFFC);
        issue(32'h8000_00EF, op_jal, 1'b1, 1'b0);
        idle(1'b0);
        chk("j_imm", ex_bundle.j_imm, 32'hFFF0_0000);
        idle(1'b1);

        // Random traffic; registers drawn from x0..x3 to provoke hazards.
        have = 1'b0;
        v = 1'b0;
        pc = '0;
        ins = '0;
        d1 = '0;
        d2 = '0;
        c = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!have) begin
                v = ($urandom % 4) != 0;
                c = mk_ctrl(ops[$urandom_range(0, 9)]);
                ins = $urandom;
                ins[6:0] = c.opcode;
                ins[11:7] = 5'($urandom_range(0, 3));
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                pc = $urandom;
                d1 = $urandom;
                d2 = $urandom;
                have = 1'b1;
            end
            er = ($urandom % 4) != 0;
            fl = ($urandom % 16) == 0;
            cycle(v, pc, ins, c, d1, d2, er, fl, g);
            if (g || !v) have = 1'b0;
        end
        idle(1'b1);
        idle(1'b1);
        chk("drain_empty", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
